otter_mem_arbiter: RTL and testbench
====================================

OTTER_MEM_ARBITER -- requirements
Module: otter_mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 8, number of consecutive cycles B may be refused before it gains tie-break priority (1..15).
REQ-002 Parameter WAIT_W, default 4, width of the wait counter.
REQ-003 MEM_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 A_REQ, A_WE, A_SIGN  in  1 each  CPU data requester: request, write enable, load sign (1 = unsigned).
REQ-006 A_ADDR, A_DIN  in  32 each; A_SIZE  in  2  CPU data address, write data and access size.
REQ-007 A_GNT  out  1; A_RVALID  out  1; A_RDATA  out  32  CPU grant, read-data valid and read data.
REQ-008 B_REQ, B_WE, B_SIGN, B_ADDR, B_DIN, B_SIZE, B_GNT, B_RVALID, B_RDATA  same widths as the A set  programmer/DMA requester.
REQ-009 MEM_ADDR2  out  32; MEM_DIN2  out  32; MEM_WRITE2, MEM_READ2  out  1 each; MEM_SIZE  out  2; MEM_SIGN  out  1  drive the data port of the byte-addressable memory.
REQ-010 MEM_DOUT2  in  32  data port read result, valid one cycle after MEM_READ2.

Function
REQ-011 Grant SHALL be combinational: at most one of A_GNT and B_GNT is high in any cycle; a grant is given only to a requester whose REQ is high.
REQ-012 Arbitration: PRI_A state: A wins if A_REQ, else B wins if B_REQ; PRI_B state: B wins if B_REQ, else A wins if A_REQ.
REQ-013 The winner's ADDR/DIN/SIZE/SIGN SHALL be muxed onto the MEM_* outputs; MEM_WRITE2 = GNT & WE and MEM_READ2 = GNT & ~WE of the winner; with no grant, MEM_WRITE2 = MEM_READ2 = 0 and the address/data outputs are 0.
REQ-014 Requesters SHALL hold REQ and all request fields stable until GNT; the access is issued in the GNT cycle, and a new request may follow in the next cycle (one access per cycle).
REQ-015 Read return: owner register records the reader at each read grant; in the next cycle that owner's RVALID = 1 and its RDATA = MEM_DOUT2; the other requester's RVALID = 0 and RDATA = 0.
REQ-016 Writes SHALL NOT produce RVALID.
REQ-017 Wait counter: increments (saturating at MAX_WAIT) in each cycle with B_REQ=1 and B_GNT=0; clears when B_REQ=0 or B_GNT=1.
REQ-018 FSM PRI_A -> PRI_B when the counter reaches MAX_WAIT; PRI_B -> PRI_A in the cycle after the first B grant in PRI_B; PRI_B with B_REQ dropped -> PRI_A.
REQ-019 Back-to-back reads from alternating requesters SHALL each return to the correct owner with no bubble.

Reset
REQ-020 While RST is high: FSM = PRI_A, wait counter = 0, owner register = none, all RVALID/RDATA = 0.
REQ-021 Reset asserted with a read in flight SHALL discard it: no RVALID follows release.
REQ-022 GNT and MEM_* outputs remain combinational from the requests during reset, but no grant is given while RST is high.

Configuration
REQ-023 Macro OTTER_ARB_STARVE_EN defined: the wait counter and PRI_B state are present as described in REQ-017 and REQ-018.
REQ-024 OTTER_ARB_STARVE_EN undefined: no counter; the FSM stays in PRI_A permanently and A has strict priority.

Structure
REQ-025 A shared package otter_mem_pkg SHALL hold the arbiter state enum (PRI_A, PRI_B), the owner enum (NONE, OWN_A, OWN_B), the size constants (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2) and the IO base address 32'h11000000.
REQ-026 Sub-module otter_arb_starve_ctr SHALL contain the wait counter and FSM; it is instantiated only under OTTER_ARB_STARVE_EN.

Verification
REQ-027 A-only read of 0x100 with MEM_DOUT2 = 0xDEADBEEF next cycle -> A_GNT same cycle, MEM_READ2=1, MEM_ADDR2=0x100; next cycle A_RVALID=1, A_RDATA=0xDEADBEEF, B_RVALID=0.
REQ-028 A and B request every cycle, MAX_WAIT=8, macro on -> B refused for 8 cycles, granted on the 9th, then A regains priority; macro off -> B never granted.
REQ-029 Alternating reads A@0x10 then B@0x20 -> RVALID on A then on B in consecutive cycles, each with its own data.
REQ-030 B write 0x11000000 data 0x5A, SIZE=2 -> MEM_WRITE2=1, MEM_DIN2=0x5A, MEM_SIZE=2; no RVALID on either side.
REQ-031 RST pulsed in the cycle after an A read grant -> A_RVALID stays 0; FSM = PRI_A and counter = 0 after release.

Source files
------------

// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared types and constants for the OTTER data-port arbiter
package otter_mem_pkg;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  localparam logic [1:0]  SZ_BYTE      = 2'd0;
  localparam logic [1:0]  SZ_HALF      = 2'd1;
  localparam logic [1:0]  SZ_WORD      = 2'd2;
  localparam logic [31:0] IO_BASE_ADDR = 32'h1100_0000;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// rtl/otter_mem_arbiter_if.sv - requester A/B and memory data-port bundle
interface otter_mem_arbiter_if;

  logic        A_REQ, A_WE, A_SIGN;
  logic [31:0] A_ADDR, A_DIN;
  logic [1:0]  A_SIZE;
  logic        A_GNT, A_RVALID;
  logic [31:0] A_RDATA;

  logic        B_REQ, B_WE, B_SIGN;
  logic [31:0] B_ADDR, B_DIN;
  logic [1:0]  B_SIZE;
  logic        B_GNT, B_RVALID;
  logic [31:0] B_RDATA;

  logic [31:0] MEM_ADDR2, MEM_DIN2;
  logic        MEM_WRITE2, MEM_READ2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  modport slave (
    input  A_REQ, A_WE, A_SIGN, A_ADDR, A_DIN, A_SIZE,
    input  B_REQ, B_WE, B_SIGN, B_ADDR, B_DIN, B_SIZE,
    input  MEM_DOUT2,
    output A_GNT, A_RVALID, A_RDATA,
    output B_GNT, B_RVALID, B_RDATA,
    output MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
  );

  modport master (
    output A_REQ, A_WE, A_SIGN, A_ADDR, A_DIN, A_SIZE,
    output B_REQ, B_WE, B_SIGN, B_ADDR, B_DIN, B_SIZE,
    output MEM_DOUT2,
    input  A_GNT, A_RVALID, A_RDATA,
    input  B_GNT, B_RVALID, B_RDATA,
    input  MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
  );

endinterface

// File: rtl/otter_arb_starve_ctr.sv
// rtl/otter_arb_starve_ctr.sv - B starvation counter and priority FSM
// (instantiated only when OTTER_ARB_STARVE_EN is defined)
module otter_arb_starve_ctr
  import otter_mem_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       b_req_i,
  input  logic       b_gnt_i,
  output arb_state_e state_o
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PRI_A;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    wait_d  = wait_q;
    state_d = state_q;

    if (!b_req_i || b_gnt_i) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end

    // Switching on the incoming count lets B win in the very next cycle.
    unique case (state_q)
      PRI_A:   if (wait_d == WAIT_MAX) state_d = PRI_B;
      PRI_B:   if (b_gnt_i || !b_req_i) state_d = PRI_A;
      default: state_d = PRI_A;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/otter_mem_arbiter.sv
// rtl/otter_mem_arbiter.sv - two-requester arbiter for the OTTER memory data port
// Define OTTER_ARB_STARVE_EN to let a starved B requester take priority.
module otter_mem_arbiter
  import otter_mem_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input logic                 MEM_CLK,
  input logic                 RST,
  otter_mem_arbiter_if.slave  bus
);

  arb_state_e state;
  logic       gnt_a, gnt_b;
  owner_e     owner_q, owner_d;

`ifdef OTTER_ARB_STARVE_EN
  otter_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_starve (
    .clk_i   (MEM_CLK),
    .rst_i   (RST),
    .b_req_i (bus.B_REQ),
    .b_gnt_i (gnt_b),
    .state_o (state)
  );
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(MAX_WAIT) ^ 32'(WAIT_W);
  assign state      = PRI_A;
`endif

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!RST) begin
      if (state == PRI_B) begin
        gnt_b = bus.B_REQ;
        gnt_a = bus.A_REQ & ~bus.B_REQ;
      end else begin
        gnt_a = bus.A_REQ;
        gnt_b = bus.B_REQ & ~bus.A_REQ;
      end
    end
  end

  always_comb begin
    bus.MEM_ADDR2  = '0;
    bus.MEM_DIN2   = '0;
    bus.MEM_SIZE   = '0;
    bus.MEM_SIGN   = 1'b0;
    bus.MEM_WRITE2 = 1'b0;
    bus.MEM_READ2  = 1'b0;
    owner_d        = NONE;
    if (gnt_a) begin
      bus.MEM_ADDR2  = bus.A_ADDR;
      bus.MEM_DIN2   = bus.A_DIN;
      bus.MEM_SIZE   = bus.A_SIZE;
      bus.MEM_SIGN   = bus.A_SIGN;
      bus.MEM_WRITE2 = bus.A_WE;
      bus.MEM_READ2  = ~bus.A_WE;
      owner_d        = bus.A_WE ? NONE : OWN_A;
    end else if (gnt_b) begin
      bus.MEM_ADDR2  = bus.B_ADDR;
      bus.MEM_DIN2   = bus.B_DIN;
      bus.MEM_SIZE   = bus.B_SIZE;
      bus.MEM_SIGN   = bus.B_SIGN;
      bus.MEM_WRITE2 = bus.B_WE;
      bus.MEM_READ2  = ~bus.B_WE;
      owner_d        = bus.B_WE ? NONE : OWN_B;
    end
  end

  // The memory answers one cycle after the read, so the owner is tracked for one cycle.
  always_ff @(posedge MEM_CLK or posedge RST) begin
    if (RST) begin
      owner_q <= NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign bus.A_GNT    = gnt_a;
  assign bus.B_GNT    = gnt_b;
  assign bus.A_RVALID = (owner_q == OWN_A);
  assign bus.B_RVALID = (owner_q == OWN_B);
  assign bus.A_RDATA  = (owner_q == OWN_A) ? bus.MEM_DOUT2 : '0;
  assign bus.B_RDATA  = (owner_q == OWN_B) ? bus.MEM_DOUT2 : '0;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb/tb_otter_mem_arbiter.sv - scoreboard bench for otter_mem_arbiter
module tb_otter_mem_arbiter;
  import otter_mem_pkg::*;

  localparam int MAX_WAIT = 8;
`ifdef OTTER_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  typedef struct packed {
    logic        req, we, sign;
    logic [1:0]  size;
    logic [31:0] addr, din;
  } req_t;

  typedef struct packed {
    logic        ga, gb;
    logic [31:0] addr, din;
    logic        we, re;
    logic [1:0]  size;
    logic        sign;
  } bus_t;

  typedef struct packed {
    logic        is_b;
    logic [31:0] data;
    int          cyc;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  otter_mem_arbiter_if bus();

  otter_mem_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (4)
  ) dut (
    .MEM_CLK (clk),
    .RST     (rst),
    .bus     (bus)
  );

  bus_t        exp_q[$];
  rd_t         rd_q[$];
  req_t        a_r, b_r;
  int          cyc      = 0;
  int          refusals = 0;
  int          n_chk    = 0;
  int          n_pass   = 0;
  bit          mon_en   = 1'b0;
  logic        rd_pend  = 1'b0;
  logic [31:0] rd_addr  = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic req_t mk(input logic we, input logic [31:0] addr, input logic [31:0] din,
                              input logic [1:0] size, input logic sign);
    req_t r;
    r.req = 1'b1; r.we = we; r.addr = addr; r.din = din; r.size = size; r.sign = sign;
    return r;
  endfunction

  function automatic req_t rand_req(input bit rd_only);
    logic [31:0] addr;
    addr = ($urandom_range(0, 7) == 0) ? IO_BASE_ADDR + ($urandom & 32'hFC) : ($urandom & 32'h3FC);
    return mk(rd_only ? 1'b0 : ($urandom_range(0, 2) == 0), addr, $urandom,
              2'($urandom_range(0, 2)), 1'($urandom));
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Memory: read data appears one cycle after a sampled read strobe.
  always @(negedge clk) begin
    rd_pend = bus.MEM_READ2;
    rd_addr = bus.MEM_ADDR2;
  end
  always @(posedge clk) bus.MEM_DOUT2 = rd_pend ? mem_rd(rd_addr) : $urandom;

  // One cycle of stimulus plus the reference prediction for it.
  task automatic step(input logic r);
    bus_t e;
    req_t w;
    logic ga, gb, b_first;
    @(posedge clk);
    #1;
    cyc++;
    rst    = r;
    mon_en = 1'b1;
    bus.A_REQ = a_r.req; bus.A_WE = a_r.we; bus.A_SIGN = a_r.sign;
    bus.A_ADDR = a_r.addr; bus.A_DIN = a_r.din; bus.A_SIZE = a_r.size;
    bus.B_REQ = b_r.req; bus.B_WE = b_r.we; bus.B_SIGN = b_r.sign;
    bus.B_ADDR = b_r.addr; bus.B_DIN = b_r.din; bus.B_SIZE = b_r.size;
    if (r) rd_q.delete();
    ga = 1'b0;
    gb = 1'b0;
    if (!r) begin
      b_first = STARVE && (refusals >= MAX_WAIT);
      if (a_r.req && b_r.req) begin
        ga = !b_first;
        gb = b_first;
      end else begin
        ga = a_r.req;
        gb = b_r.req;
      end
    end
    refusals = (r || !b_r.req || gb) ? 0 : refusals + 1;
    e = '0;
    e.ga = ga;
    e.gb = gb;
    if (ga || gb) begin
      w = ga ? a_r : b_r;
      e.addr = w.addr; e.din = w.din; e.size = w.size; e.sign = w.sign;
      e.we = w.we; e.re = !w.we;
      if (!w.we) rd_q.push_back('{gb, mem_rd(w.addr), cyc + 1});
    end
    exp_q.push_back(e);
    if (ga) a_r.req = 1'b0;
    if (gb) b_r.req = 1'b0;
  endtask

  task automatic contend(input int n);
    for (int i = 0; i < n; i++) begin
      if (!a_r.req) a_r = rand_req(1'b1);
      if (!b_r.req) b_r = rand_req(1'b1);
      step(1'b0);
    end
  endtask

  always @(negedge clk) begin : monitor
    bus_t act, e;
    rd_t  rd;
    if (mon_en) begin
      act.ga = bus.A_GNT; act.gb = bus.B_GNT;
      act.addr = bus.MEM_ADDR2; act.din = bus.MEM_DIN2;
      act.we = bus.MEM_WRITE2; act.re = bus.MEM_READ2;
      act.size = bus.MEM_SIZE; act.sign = bus.MEM_SIGN;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL bus_expect cycle %0d: no prediction queued", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("bus", 128'(act), 128'(e));
      end

      if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        rd = rd_q.pop_front();
        n_chk++;
        $display("FAIL rvalid_missing cycle %0d: got none required at cycle %0d", cyc, rd.cyc);
      end

      if (bus.A_RVALID || bus.B_RVALID) begin
        if (rd_q.size() == 0) begin
          n_chk++;
          $display("FAIL rvalid_unexpected cycle %0d: got A=%0b B=%0b required none",
                   cyc, bus.A_RVALID, bus.B_RVALID);
        end else begin
          rd = rd_q.pop_front();
          chk("rvalid_cycle", 128'(cyc), 128'(rd.cyc));
          chk("rvalid_owner", {bus.A_RVALID, bus.B_RVALID}, rd.is_b ? 2'b01 : 2'b10);
          chk("rdata", rd.is_b ? bus.B_RDATA : bus.A_RDATA, rd.data);
          chk("rdata_other", rd.is_b ? bus.A_RDATA : bus.B_RDATA, 32'h0);
        end
      end else begin
        chk("rdata_idle", {bus.A_RDATA, bus.B_RDATA}, 64'h0);
      end
    end
  end

  initial begin
    a_r = '0;
    b_r = '0;
    bus.A_REQ = 1'b0; bus.A_WE = 1'b0; bus.A_SIGN = 1'b0;
    bus.A_ADDR = '0; bus.A_DIN = '0; bus.A_SIZE = '0;
    bus.B_REQ = 1'b0; bus.B_WE = 1'b0; bus.B_SIGN = 1'b0;
    bus.B_ADDR = '0; bus.B_DIN = '0; bus.B_SIZE = '0;

    // Reset holds off grants even with both sides requesting.
    a_r = rand_req(1'b0);
    b_r = rand_req(1'b0);
    step(1'b1);
    step(1'b1);
    a_r.req = 1'b0;
    b_r.req = 1'b0;
    step(1'b1);
    step(1'b0);

    // A-only read of 0x100.
    a_r = mk(1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0);
    step(1'b0);
    step(1'b0);

    // B write to the IO base.
    b_r = mk(1'b1, IO_BASE_ADDR, 32'h5A, SZ_WORD, 1'b0);
    step(1'b0);
    step(1'b0);

    // Back-to-back reads: A then B.
    a_r = mk(1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0);
    b_r = mk(1'b0, 32'h20, 32'h0, SZ_HALF, 1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b0);

    // Continuous contention from both sides.
    contend(30);
    a_r.req = 1'b0;
    b_r.req = 1'b0;
    step(1'b0);
    step(1'b0);

    // Reset right after an A read grant discards the return.
    a_r = mk(1'b0, 32'h40, 32'h0, SZ_BYTE, 1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    contend(20);

    for (int i = 0; i < 3000; i++) begin
      if (!a_r.req && $urandom_range(0, 99) < 60) a_r = rand_req(1'b0);
      if (!b_r.req && $urandom_range(0, 99) < 60) b_r = rand_req(1'b0);
      step(1'($urandom_range(0, 149) == 0));
    end

    for (int i = 0; i < 5; i++) step(1'b0);
    @(negedge clk);
    #1;
    chk("rd_drain", 128'(rd_q.size()), 128'(0));
    chk("bus_drain", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
